serial_adder_n: RTL and testbench
=================================

SERIAL_ADDER_N -- requirements
Module: serial_adder_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a new operation.
REQ-005 The block SHALL have port mode_sub, input, 1 bit: 0 selects x+y, 1 selects x-y.
REQ-006 The block SHALL have port acc, input, 1 bit: 1 selects the previous sum[WIDTH-1:0] as operand x instead of the x port.
REQ-007 The block SHALL have port x, input, WIDTH bits: operand x.
REQ-008 The block SHALL have port y, input, WIDTH bits: operand y.
REQ-009 The block SHALL have port busy, output, 1 bit: operation in progress.
REQ-010 The block SHALL have port done, output, 1 bit: sum and ovf are valid.
REQ-011 The block SHALL have port sum, output, WIDTH+1 bits: result; bit WIDTH is carry (add) or borrow (sub).
REQ-012 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow of the WIDTH-bit result.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE; busy=1 only in RUN; done=1 only in DONE.
REQ-014 In IDLE or DONE, start=1 at a rising edge SHALL capture mode_sub, operand x (or sum[WIDTH-1:0] if acc=1), y, clear the bit counter, clear sum, and enter RUN.
REQ-015 The carry register SHALL initialise to 0 for add and to 1 for sub; y bits SHALL be inverted for sub.
REQ-016 RUN SHALL process one bit per cycle, LSB first, as a 1-bit full adder: sum bit i = xi ^ yi' ^ c, c' = majority(xi, yi', c).
REQ-017 Bit i SHALL be written into sum[i] at the (i+1)-th RUN edge.
REQ-018 After exactly WIDTH RUN edges the FSM SHALL enter DONE, with latency = WIDTH cycles from the start-sampling edge to done=1.
REQ-019 On entering DONE, sum[WIDTH] SHALL be the final carry for add and the inverted final carry (borrow) for sub.
REQ-020 On entering DONE, ovf SHALL equal carry-into-MSB XOR carry-out-of-MSB.
REQ-021 sum, ovf and done SHALL hold in DONE until the next accepted start.
REQ-022 A start accepted in DONE SHALL move directly to RUN, with no IDLE cycle and done low in the next cycle.
REQ-023 start while in RUN SHALL be ignored, with no queuing and no effect on the operation in progress.
REQ-024 Changes on x, y, mode_sub or acc during RUN SHALL NOT affect the result.
REQ-025 acc=1 with no prior completed operation SHALL use sum[WIDTH-1:0] = 0 as operand x.
REQ-026 Result arithmetic SHALL be modulo 2^WIDTH in sum[WIDTH-1:0] with no saturation.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for a clock edge, force IDLE, busy=0, done=0, sum=0, ovf=0, carry=0 and counter=0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation with no partial result retained.
REQ-029 After rst_n deasserts, the first start SHALL be accepted at the next rising edge.

Verification
REQ-030 WIDTH=4, add, x=9, y=7, start for 1 cycle -> busy for 4 cycles, then done=1, sum=5'b10000, ovf=0.
REQ-031 WIDTH=4, sub, x=3, y=5 -> sum[3:0]=4'b1110, sum[4]=1 (borrow), ovf=0; x=5, y=3 -> sum=5'b00010.
REQ-032 WIDTH=4, add, x=7, y=1 -> sum=5'b01000, ovf=1; sub, x=8, y=1 -> sum[3:0]=4'b0111, ovf=1.
REQ-033 Accumulate: x=3, y=4 add, then acc=1, y=2 add -> second result sum[3:0]=9, with start issued in DONE and no IDLE cycle.
REQ-034 start pulsed and operands changed at RUN cycle 2 -> result unchanged, no second operation; rst_n low at RUN cycle 2 -> all outputs 0 immediately, FSM in IDLE.
REQ-035 WIDTH=8 and WIDTH=2 random add/sub, 1000 vectors vs reference model -> sum and ovf match, latency = WIDTH cycles.

Source files
------------

// File: rtl/serial_adder_n.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder step per clock, LSB first,
// with an accumulate option that feeds the previous result back in as operand x.
module serial_adder_n #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode_sub,
    input  logic             acc,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   sum,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] xs_q, xs_d;
    logic [WIDTH-1:0] ys_q, ys_d;
    logic             mode_q, mode_d;
    logic             carry_q, carry_d;
    logic [WIDTH:0]   sum_q, sum_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bit_s;
    logic             cout_s;

    // Operands sit in shift registers so the current bit is always at position 0;
    // ys_q already holds ~y for subtraction.
    always_comb begin
        bit_s  = xs_q[0] ^ ys_q[0] ^ carry_q;
        cout_s = (xs_q[0] & ys_q[0]) | (xs_q[0] & carry_q) | (ys_q[0] & carry_q);
    end

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        mode_d  = mode_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    mode_d  = mode_sub;
                    xs_d    = acc ? sum_q[WIDTH-1:0] : x;
                    ys_d    = mode_sub ? ~y : y;
                    carry_d = mode_sub;
                    cnt_d   = '0;
                    sum_d   = '0;
                    ovf_d   = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_RUN: begin
                sum_d[WIDTH-1:0] = sum_q[WIDTH-1:0] | ({{(WIDTH-1){1'b0}}, bit_s} << cnt_q);
                xs_d    = xs_q >> 1'b1;
                ys_d    = ys_q >> 1'b1;
                carry_d = cout_s;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // carry_q is the carry into the MSB, cout_s the carry out of it
                    state_d      = S_DONE;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    sum_d[WIDTH] = cout_s ^ mode_q;
                    ovf_d        = carry_q ^ cout_s;
                    cnt_d        = '0;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                cnt_d   = '0;
                carry_d = 1'b0;
                sum_d   = '0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            xs_q    <= '0;
            ys_q    <= '0;
            mode_q  <= 1'b0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            mode_q  <= mode_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_n.sv
// Directed bench for serial_adder_n: WIDTH=4 hand-computed cases plus
// WIDTH=8 / WIDTH=2 instances sharing stimulus, checked against an arithmetic model.
module tb_serial_adder_n;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start_a, mode_a, acc_a;
    logic [3:0] x_a, y_a;
    logic       busy_a, done_a, ovf_a;
    logic [4:0] sum_a;

    logic       start_b, mode_b, acc_b;
    logic [7:0] x_b, y_b;
    logic       busy8, done8, ovf8;
    logic [8:0] sum8;
    logic       busy2, done2, ovf2;
    logic [2:0] sum2;

    int n_cmp = 0;
    int n_err = 0;

    serial_adder_n #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start_a), .mode_sub(mode_a), .acc(acc_a),
        .x(x_a), .y(y_a), .busy(busy_a), .done(done_a), .sum(sum_a), .ovf(ovf_a)
    );

    serial_adder_n #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start_b), .mode_sub(mode_b), .acc(acc_b),
        .x(x_b), .y(y_b), .busy(busy8), .done(done8), .sum(sum8), .ovf(ovf8)
    );

    serial_adder_n #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_b), .mode_sub(mode_b), .acc(acc_b),
        .x(x_b[1:0]), .y(y_b[1:0]), .busy(busy2), .done(done2), .sum(sum2), .ovf(ovf2)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, sum[32:0]} for a w-bit add/sub.
    function automatic logic [33:0] model(input int w, input logic sub,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [63:0] mask, aa, bb, bi, full, res, s;
        logic        c, sa, sb, sr, ov;
        mask = (64'd1 << w) - 64'd1;
        aa   = {32'd0, a} & mask;
        bb   = {32'd0, b} & mask;
        bi   = sub ? (~bb & mask) : bb;
        full = aa + bi + {63'd0, sub};
        c    = full[w];
        res  = full & mask;
        sa   = aa[w-1];
        sb   = bb[w-1];
        sr   = res[w-1];
        ov   = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        s    = res | ({63'd0, sub ^ c} << w);
        return {ov, s[32:0]};
    endfunction

    task automatic op_a(input logic m, input logic ac, input logic [3:0] xv, input logic [3:0] yv);
        @(negedge clk);
        start_a = 1'b1; mode_a = m; acc_a = ac; x_a = xv; y_a = yv;
        @(negedge clk);
        start_a = 1'b0;
        chk("busy_after_start", {63'd0, busy_a}, 64'd1);
        chk("done_low_after_start", {63'd0, done_a}, 64'd0);
    endtask

    // n_already: RUN edges elapsed since the start-sampling edge before the call.
    task automatic wait_a(input int n_already);
        int n;
        n = n_already;
        while (done_a !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("latency_w4", n, 64'd4);
    endtask

    task automatic op_b(input logic m, input logic [7:0] a, input logic [7:0] b);
        int l8, l2;
        logic [33:0] e8, e2;
        l8 = -1; l2 = -1;
        @(negedge clk);
        start_b = 1'b1; mode_b = m; x_b = a; y_b = b;
        @(negedge clk);
        start_b = 1'b0;
        x_b = ~a; y_b = ~b; mode_b = ~m;
        for (int n = 0; n < 40; n++) begin
            if (l2 < 0 && done2 === 1'b1) l2 = n;
            if (l8 < 0 && done8 === 1'b1) l8 = n;
            if (l2 >= 0 && l8 >= 0) break;
            @(negedge clk);
        end
        e8 = model(8, m, {24'd0, a}, {24'd0, b});
        e2 = model(2, m, {30'd0, a[1:0]}, {30'd0, b[1:0]});
        chk("latency_w8", l8, 64'd8);
        chk("latency_w2", l2, 64'd2);
        chk("sum_w8", {55'd0, sum8}, {55'd0, e8[8:0]});
        chk("ovf_w8", {63'd0, ovf8}, {63'd0, e8[33]});
        chk("sum_w2", {61'd0, sum2}, {61'd0, e2[2:0]});
        chk("ovf_w2", {63'd0, ovf2}, {63'd0, e2[33]});
    endtask

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; mode_a = 1'b0; acc_a = 1'b0; x_a = 4'd0; y_a = 4'd0;
        start_b = 1'b0; mode_b = 1'b0; acc_b = 1'b0; x_b = 8'd0; y_b = 8'd0;
        #12;
        chk("reset_busy", {63'd0, busy_a}, 64'd0);
        chk("reset_done", {63'd0, done_a}, 64'd0);
        chk("reset_sum", {59'd0, sum_a}, 64'd0);
        chk("reset_ovf", {63'd0, ovf_a}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 9 + 7 = 16: carry out, no signed overflow
        op_a(1'b0, 1'b0, 4'd9, 4'd7);
        wait_a(0);
        chk("add_9_7_sum", {59'd0, sum_a}, 64'h10);
        chk("add_9_7_ovf", {63'd0, ovf_a}, 64'd0);
        chk("add_9_7_busy_low", {63'd0, busy_a}, 64'd0);

        // 3 - 5: borrow set, result 1110
        op_a(1'b1, 1'b0, 4'd3, 4'd5);
        wait_a(0);
        chk("sub_3_5_sum", {59'd0, sum_a}, 64'h1E);
        chk("sub_3_5_ovf", {63'd0, ovf_a}, 64'd0);

        op_a(1'b1, 1'b0, 4'd5, 4'd3);
        wait_a(0);
        chk("sub_5_3_sum", {59'd0, sum_a}, 64'h02);
        chk("sub_5_3_ovf", {63'd0, ovf_a}, 64'd0);

        // signed overflow boundaries: 7+1 and -8-1
        op_a(1'b0, 1'b0, 4'd7, 4'd1);
        wait_a(0);
        chk("add_7_1_sum", {59'd0, sum_a}, 64'h08);
        chk("add_7_1_ovf", {63'd0, ovf_a}, 64'd1);

        op_a(1'b1, 1'b0, 4'd8, 4'd1);
        wait_a(0);
        chk("sub_8_1_sum", {59'd0, sum_a}, 64'h07);
        chk("sub_8_1_ovf", {63'd0, ovf_a}, 64'd1);

        // accumulate: 3+4=7, then 7+2=9 started straight from DONE
        op_a(1'b0, 1'b0, 4'd3, 4'd4);
        wait_a(0);
        chk("acc_first_sum", {59'd0, sum_a}, 64'h07);
        op_a(1'b0, 1'b1, 4'd15, 4'd2);
        wait_a(0);
        chk("acc_second_sum", {59'd0, sum_a}, 64'h09);
        chk("acc_second_ovf", {63'd0, ovf_a}, 64'd1);

        // start and operand changes during RUN are ignored
        op_a(1'b0, 1'b0, 4'd2, 4'd3);
        @(negedge clk);
        start_a = 1'b1; mode_a = 1'b1; acc_a = 1'b1; x_a = 4'd15; y_a = 4'd15;
        @(negedge clk);
        start_a = 1'b0;
        wait_a(2);
        chk("ignore_start_sum", {59'd0, sum_a}, 64'h05);
        chk("ignore_start_ovf", {63'd0, ovf_a}, 64'd0);
        repeat (3) @(negedge clk);
        chk("no_second_op_done", {63'd0, done_a}, 64'd1);
        chk("no_second_op_busy", {63'd0, busy_a}, 64'd0);
        chk("hold_sum", {59'd0, sum_a}, 64'h05);

        // reset mid-RUN clears everything without a clock edge
        op_a(1'b0, 1'b0, 4'd9, 4'd7);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_busy", {63'd0, busy_a}, 64'd0);
        chk("midrun_rst_done", {63'd0, done_a}, 64'd0);
        chk("midrun_rst_sum", {59'd0, sum_a}, 64'd0);
        chk("midrun_rst_ovf", {63'd0, ovf_a}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // first start after reset is accepted; acc uses zero as x
        op_a(1'b0, 1'b1, 4'd15, 4'd6);
        wait_a(0);
        chk("acc_after_reset_sum", {59'd0, sum_a}, 64'h06);
        chk("acc_after_reset_ovf", {63'd0, ovf_a}, 64'd0);

        // WIDTH=8 and WIDTH=2 corner vectors, then random ones
        op_b(1'b0, 8'hFF, 8'h01);
        op_b(1'b1, 8'h80, 8'h01);
        op_b(1'b0, 8'h7F, 8'h7F);
        op_b(1'b1, 8'h00, 8'hFF);
        for (int i = 0; i < 1000; i++) begin
            op_b(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
